alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_core.sv | 77 +++++++
 rtl/alu_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_seq.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, FSM states
// and flag bit positions within the ZCFNL flag vector.
package alu_pkg;

    localparam int unsigned OP_W   = 5;
    localparam int unsigned FLAG_W = 5;

    localparam int unsigned FLAG_Z = 4;
    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_L = 0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 5'd0,
        OP_AND   = 5'd1,
        OP_OR    = 5'd2,
        OP_XOR   = 5'd3,
        OP_NOT   = 5'd4,
        OP_ADD   = 5'd5,
        OP_ADDU  = 5'd6,
        OP_ADDC  = 5'd7,
        OP_ADDCU = 5'd8,
        OP_SUB   = 5'd9,
        OP_CMP   = 5'd10,
        OP_CMPU  = 5'd11,
        OP_LSH   = 5'd12,
        OP_RSH   = 5'd13,
        OP_ARSH  = 5'd14,
        OP_MUL   = 5'd15
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic is_shift(input logic [OP_W-1:0] op);
        return (op == OP_LSH) || (op == OP_RSH) || (op == OP_ARSH);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bus of the sequential ALU: valid/ready request with
// operands, valid/ready response with result and flags.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 16
);
    import alu_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [OP_W-1:0]     op;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    result;
    logic [FLAG_W-1:0]   flags;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: single-cycle ops plus flag generation for every op class.
// Shift and multiply results arrive already iterated via iter_res_i.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [OP_W-1:0]   op_i,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    input  logic              cin_i,
    input  logic [WIDTH-1:0]  iter_res_i,
    input  logic              iter_hi_nz_i,
    output logic [WIDTH-1:0]  result_c_o,
    output logic [FLAG_W-1:0] flags_c_o
);

    localparam int unsigned XW = WIDTH + 1;

    logic [XW-1:0] add_sum;
    logic [XW-1:0] sub_diff;
    logic          add_cin;
    logic          use_z;

    always_comb begin
        add_cin    = ((op_i == OP_ADDC) || (op_i == OP_ADDCU)) ? cin_i : 1'b0;
        add_sum    = {1'b0, a_i} + {1'b0, b_i} + XW'(add_cin);
        sub_diff   = {1'b0, a_i} - {1'b0, b_i};
        result_c_o = '0;
        flags_c_o  = '0;
        use_z      = 1'b1;
        case (op_i)
            OP_AND:  result_c_o = a_i & b_i;
            OP_OR:   result_c_o = a_i | b_i;
            OP_XOR:  result_c_o = a_i ^ b_i;
            OP_NOT:  result_c_o = ~a_i;
            OP_ADD, OP_ADDC: begin
                result_c_o        = add_sum[WIDTH-1:0];
                flags_c_o[FLAG_C] = add_sum[WIDTH];
                flags_c_o[FLAG_F] = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                                    (add_sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_ADDU, OP_ADDCU: begin
                result_c_o        = add_sum[WIDTH-1:0];
                flags_c_o[FLAG_C] = add_sum[WIDTH];
            end
            OP_SUB: begin
                result_c_o        = sub_diff[WIDTH-1:0];
                flags_c_o[FLAG_C] = sub_diff[WIDTH];
                flags_c_o[FLAG_F] = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                                    (sub_diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            // Compares report equality, not result==0
            OP_CMP: begin
                use_z             = 1'b0;
                flags_c_o[FLAG_Z] = (a_i == b_i);
                flags_c_o[FLAG_N] = $signed(a_i) < $signed(b_i);
                flags_c_o[FLAG_L] = $signed(a_i) < $signed(b_i);
            end
            OP_CMPU: begin
                use_z             = 1'b0;
                flags_c_o[FLAG_Z] = (a_i == b_i);
                flags_c_o[FLAG_L] = (a_i < b_i);
            end
            OP_LSH, OP_RSH, OP_ARSH: result_c_o = iter_res_i;
            OP_MUL: begin
                result_c_o        = iter_res_i;
                flags_c_o[FLAG_C] = iter_hi_nz_i;
            end
            default: use_z = 1'b0;
        endcase
        if (use_z) begin
            flags_c_o[FLAG_Z] = ~|result_c_o;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU top: accept/complete handshake FSM, bit-serial shifter and
// shift-add multiplier; single-cycle ops and flags come from alu_core.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic        clk,
    input  logic        reset,
    alu_seq_if.slave    bus
);

    localparam int unsigned CNT_W = SHW + 1;
    localparam int unsigned XW    = WIDTH + 1;
    localparam int unsigned PW    = 2 * WIDTH;

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [PW-1:0]     prod_q, prod_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              out_valid_q, out_valid_d;

    logic              in_ready_c;
    logic              accept_c;
    logic              finish_c;
    logic [WIDTH-1:0]  shift_step_c;
    logic [XW-1:0]     mul_add_c;
    logic [PW-1:0]     mul_step_c;
    logic [OP_W-1:0]   core_op_c;
    logic [WIDTH-1:0]  core_iter_c;
    logic              core_hi_nz_c;
    logic [WIDTH-1:0]  core_result_c;
    logic [FLAG_W-1:0] core_flags_c;

    assign in_ready_c    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    assign accept_c      = bus.in_valid && in_ready_c;
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

    // One shift step and one shift-add multiply step per cycle
    always_comb begin
        case (op_q)
            OP_LSH:  shift_step_c = shift_q << 1;
            OP_ARSH: shift_step_c = {shift_q[WIDTH-1], shift_q[WIDTH-1:1]};
            default: shift_step_c = shift_q >> 1;
        endcase
        mul_add_c  = {1'b0, prod_q[PW-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : XW'(0));
        mul_step_c = {mul_add_c, prod_q[WIDTH-1:1]};
    end

    // Core sees live bus inputs at acceptance, the iterated value otherwise
    always_comb begin
        core_op_c    = bus.op;
        core_iter_c  = bus.a;
        core_hi_nz_c = 1'b0;
        if (state_q == ST_SHIFT) begin
            core_op_c   = op_q;
            core_iter_c = shift_step_c;
        end else if (state_q == ST_MUL) begin
            core_op_c    = op_q;
            core_iter_c  = mul_step_c[WIDTH-1:0];
            core_hi_nz_c = |mul_step_c[PW-1:WIDTH];
        end
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op_i         (core_op_c),
        .a_i          (bus.a),
        .b_i          (bus.b),
        .cin_i        (flags_q[FLAG_C]),
        .iter_res_i   (core_iter_c),
        .iter_hi_nz_i (core_hi_nz_c),
        .result_c_o   (core_result_c),
        .flags_c_o    (core_flags_c)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        shift_d     = shift_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        finish_c    = 1'b0;

        unique case (state_q)
            ST_SHIFT: begin
                shift_d = shift_step_c;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    finish_c = 1'b1;
                end
            end
            ST_MUL: begin
                prod_d = mul_step_c;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    finish_c = 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: ;
        endcase

        // A new request may be taken in the same cycle DONE is drained
        if (accept_c) begin
            op_d = bus.op;
            a_d  = bus.a;
            if (is_shift(bus.op) && (bus.b[SHW-1:0] != '0)) begin
                state_d = ST_SHIFT;
                shift_d = bus.a;
                cnt_d   = CNT_W'(bus.b[SHW-1:0]);
            end else if (bus.op == OP_MUL) begin
                state_d = ST_MUL;
                prod_d  = {{WIDTH{1'b0}}, bus.b};
                cnt_d   = CNT_W'(WIDTH);
            end else begin
                finish_c = 1'b1;
            end
        end

        if (finish_c) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            result_d    = core_result_c;
            flags_d     = core_flags_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            shift_q     <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            shift_q     <= shift_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=16: directed corner cases, stall,
// mid-multiply reset and randomised ops checked against an arithmetic model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   fl;
        int           lat;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;
    logic model_c = 1'b0;
    int   rdy_mode = 1;
    bit   pend_new = 1'b1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference behaviour from plain integer arithmetic
    function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cin);
        exp_t   e;
        longint ua, ub, sa, sbv, s, p;
        int     n;
        logic   c;
        ua = a;  ub = b;
        sa = $signed(a);  sbv = $signed(b);
        n  = int'(b[3:0]);
        c  = ((op == OP_ADDC) || (op == OP_ADDCU)) ? cin : 1'b0;
        e.res = '0;  e.fl = '0;  e.lat = 1;  e.cyc = 0;
        case (op)
            OP_AND:  e.res = a & b;
            OP_OR:   e.res = a | b;
            OP_XOR:  e.res = a ^ b;
            OP_NOT:  e.res = ~a;
            OP_ADD, OP_ADDU, OP_ADDC, OP_ADDCU: begin
                s = ua + ub + longint'(c);
                e.res = W'(s);
                e.fl[FLAG_C] = (s > 65535);
                if (op == OP_ADD || op == OP_ADDC) begin
                    s = sa + sbv + longint'(c);
                    e.fl[FLAG_F] = (s > 32767) || (s < -32768);
                end
            end
            OP_SUB: begin
                e.res = W'(ua - ub);
                e.fl[FLAG_C] = (ua < ub);
                s = sa - sbv;
                e.fl[FLAG_F] = (s > 32767) || (s < -32768);
            end
            OP_CMP: begin
                e.fl[FLAG_N] = (sa < sbv);
                e.fl[FLAG_L] = (sa < sbv);
            end
            OP_CMPU: e.fl[FLAG_L] = (ua < ub);
            OP_LSH:  begin e.res = W'(ua << n);  e.lat = n + 1; end
            OP_RSH:  begin e.res = W'(ua >> n);  e.lat = n + 1; end
            OP_ARSH: begin e.res = W'(sa >>> n); e.lat = n + 1; end
            OP_MUL: begin
                p = ua * ub;
                e.res = W'(p);
                e.fl[FLAG_C] = ((p >> 16) != 0);
                e.lat = W + 1;
            end
            default: ;
        endcase
        if (op == OP_CMP || op == OP_CMPU) e.fl[FLAG_Z] = (a == b);
        else if (op >= 5'd1 && op <= 5'd15) e.fl[FLAG_Z] = (e.res == '0);
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after acceptance
    task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit use_x, input exp_t x);
        exp_t e;
        int   guard = 0;
        bus.in_valid = 1'b1;
        bus.op = op;  bus.a = a;  bus.b = b;
        while (!bus.in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            total++;  bad++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 for op %0d", op);
        end else begin
            e = use_x ? x : model(op, a, b, model_c);
            e.cyc = cyc;
            sb.push_back(e);
            model_c = e.fl[FLAG_C];
            @(negedge clk);
        end
        // Scramble inputs after acceptance; the operation must ignore them
        bus.in_valid = 1'b0;
        bus.op = 5'($urandom);  bus.a = W'($urandom);  bus.b = W'($urandom);
    endtask

    task automatic run(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t x;
        x.res = '0;  x.fl = '0;  x.lat = 0;  x.cyc = 0;
        issue(op, a, b, 1'b0, x);
    endtask

    task automatic run_x(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic [4:0] fl, input int lat);
        exp_t x;
        x.res = res;  x.fl = fl;  x.lat = lat;  x.cyc = 0;
        issue(op, a, b, 1'b1, x);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = ($urandom_range(0, 3) != 0);
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops on each new output, checks hold-stability while stalled
    always @(negedge clk) begin
        if (reset) begin
            pend_new = 1'b1;
        end else if (bus.out_valid) begin
            if (pend_new) begin
                if (sb.size() == 0) begin
                    total++;  bad++;
                    $display("FAIL unexpected_output: result %0h flags %0h with none expected",
                             bus.result, bus.flags);
                end else begin
                    cur = sb.pop_front();
                    chk("result", 64'(bus.result), 64'(cur.res));
                    chk("flags", 64'(bus.flags), 64'(cur.fl));
                    chk("latency", 64'(cyc - cur.cyc), 64'(cur.lat));
                end
                pend_new = 1'b0;
            end else begin
                chk("held_result", 64'(bus.result), 64'(cur.res));
                chk("held_flags", 64'(bus.flags), 64'(cur.fl));
            end
            chk("in_ready_done", 64'(bus.in_ready), 64'(bus.out_ready));
            if (bus.out_ready) pend_new = 1'b1;
        end
    end

    initial begin
        int guard;
        reset = 1'b1;
        bus.in_valid = 1'b0;  bus.op = '0;  bus.a = '0;  bus.b = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_result", 64'(bus.result), 64'(0));
        chk("rst_flags", 64'(bus.flags), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

        rdy_mode = 1;
        run_x(OP_ADD,   16'h7FFF, 16'h0001, 16'h8000, 5'b00100, 1);
        run_x(OP_ADDU,  16'hFFFF, 16'h0001, 16'h0000, 5'b11000, 1);
        run_x(OP_ADDC,  16'h0000, 16'h0000, 16'h0001, 5'b00000, 1);
        run_x(OP_ARSH,  16'h8000, 16'h0004, 16'hF800, 5'b00000, 5);
        run_x(OP_RSH,   16'h8000, 16'h0004, 16'h0800, 5'b00000, 5);
        run_x(OP_LSH,   16'h8000, 16'h0000, 16'h8000, 5'b00000, 1);
        run_x(OP_MUL,   16'h0100, 16'h0100, 16'h0000, 5'b11000, 17);
        run_x(OP_MUL,   16'h00FF, 16'h0003, 16'h02FD, 5'b00000, 17);
        run_x(OP_NOP,   16'h1234, 16'h5678, 16'h0000, 5'b00000, 1);
        run_x(5'd20,    16'h0000, 16'h0000, 16'h0000, 5'b00000, 1);
        run_x(OP_CMP,   16'h8000, 16'h0001, 16'h0000, 5'b00011, 1);
        run_x(OP_CMPU,  16'h8000, 16'h0001, 16'h0000, 5'b00000, 1);
        run_x(OP_CMPU,  16'h0005, 16'h0005, 16'h0000, 5'b10000, 1);
        run_x(OP_SUB,   16'h0000, 16'h0001, 16'hFFFF, 5'b01000, 1);
        run_x(OP_SUB,   16'h8000, 16'h0001, 16'h7FFF, 5'b00100, 1);
        run_x(OP_XOR,   16'hA5A5, 16'hA5A5, 16'h0000, 5'b10000, 1);

        // Consumer stalls three cycles; next request waits then goes through
        rdy_mode = 2;
        run_x(OP_OR, 16'h00F0, 16'h0F00, 16'h0FF0, 5'b00000, 1);
        fork
            begin
                repeat (2) @(negedge clk);
                rdy_mode = 1;
            end
        join_none
        run_x(OP_AND, 16'hFF00, 16'h0FF0, 16'h0F00, 5'b00000, 1);

        // Reset in the 8th multiply cycle aborts it and clears the flags
        run_x(OP_ADDU, 16'hFFFF, 16'h0001, 16'h0000, 5'b11000, 1);
        run_x(OP_MUL,  16'h0100, 16'h0100, 16'h0000, 5'b11000, 17);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("mid_rst_flags", 64'(bus.flags), 64'(0));
        chk("mid_rst_result", 64'(bus.result), 64'(0));
        sb.delete();
        model_c = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_output", 64'(bus.out_valid), 64'(0));
        chk("abort_in_ready", 64'(bus.in_ready), 64'(1));
        run_x(OP_ADDC, 16'h0000, 16'h0000, 16'h0000, 5'b10000, 1);
        run_x(OP_ADD,  16'h1234, 16'h0001, 16'h1235, 5'b00000, 1);

        rdy_mode = 0;
        for (int i = 0; i < 250; i++) begin
            run(5'($urandom_range(0, 19)), W'($urandom), W'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        rdy_mode = 1;
        guard = 0;
        while (!(sb.size() == 0 && pend_new) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0 || !pend_new) begin
            total++;  bad++;
            $display("FAIL drain_timeout: outstanding %0d expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
